avalon_st_arbiter: RTL and testbench
====================================

AVALON_ST_ARBITER -- requirements
Module: avalon_st_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning width of each data beat.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, meaning maximum beats per grant (range 1..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port src_valid  input  4  per-source Avalon-ST valid, bit i = source i.
REQ-006 The block SHALL have port src_data  input  4*DATA_W  per-source data, source i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port src_ready  output  4  per-source ready, ready latency 0.
REQ-008 The block SHALL have port valid  output  1  registered sink-side valid.
REQ-009 The block SHALL have port ready  input  1  sink-side ready, ready latency 0.
REQ-010 The block SHALL have port data  output  DATA_W  registered sink-side data.
REQ-011 The block SHALL have port grant  output  4  registered one-hot current owner; all-zero when no owner.
REQ-012 The block SHALL have port busy  output  1  high while in state BURST.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (grant=0) and BURST (grant one-hot).
REQ-014 In IDLE with any src_valid high, the block SHALL select the first asserted source, searching from (last+1) mod 4 upward with wrap, load grant at the next edge and enter BURST.
REQ-015 In IDLE with src_valid=0, the block SHALL stay in IDLE with grant=0.
REQ-016 The output stage SHALL be "open" when valid=0 or ready=1.
REQ-017 src_ready[i] SHALL equal grant[i] AND open (combinational); all other src_ready bits SHALL be 0.
REQ-018 A source beat SHALL transfer when src_valid[g] and src_ready[g] are both high in the same cycle, g = granted index.
REQ-019 When open, valid SHALL load (transfer of a source beat this cycle) and data SHALL load src_data of g when transferring; when not open, valid and data SHALL hold unchanged.
REQ-020 Latency SHALL be one cycle from source transfer to the beat appearing on valid/data; sustained throughput SHALL be 1 beat/cycle within a burst.
REQ-021 A 4-bit beat counter SHALL clear on entry to BURST and increment on each source transfer.
REQ-022 BURST SHALL release (next state IDLE, grant cleared, last <= g) when a transfer makes the count reach MAX_BURST.
REQ-023 BURST SHALL also release when open=1 and src_valid[g]=0 (owner idle while it could send).
REQ-024 With open=0, BURST SHALL hold regardless of src_valid[g] (no release while the sink stalls).
REQ-025 Every release SHALL be followed by exactly one IDLE cycle before the next grant (one-cycle arbitration bubble on the source side).
REQ-026 A pending output beat (valid=1, ready=0) SHALL remain stable through release and IDLE until accepted.
REQ-027 src_valid changes on non-granted sources SHALL NOT affect the current burst.
REQ-028 data SHALL never be driven with X; when valid=0 it SHALL hold its last value.

Reset
REQ-029 On resetn low, asynchronously: state=IDLE, grant=0, busy=0, valid=0, data=0, count=0, last=3 (so source 0 has first priority).
REQ-030 Reset mid-burst SHALL discard any in-flight output beat; no beat SHALL be presented after reset release until a new grant transfers one.
REQ-031 src_ready SHALL be 0 while resetn is low.

Verification
REQ-032 Single source: src_valid=4'b0001, data 0x04,0x05,0x06, ready=1 -> grant=0001 one cycle later; valid high for 3 consecutive cycles with data 4,5,6; release on src_valid drop; busy falls.
REQ-033 Burst limit: src0 always valid with incrementing data, MAX_BURST=4 -> exactly 4 beats, 1 IDLE cycle, then src0 re-granted (only requester) for next 4.
REQ-034 Round-robin: all four src_valid high continuously -> grant sequence 0001,0010,0100,1000,0001, each for 4 beats, with 1 IDLE cycle between.
REQ-035 Back-pressure: ready=0 for 3 cycles mid-burst -> valid/data held constant, src_ready=0, no release; resumes with no lost or duplicated beat.
REQ-036 Reset mid-burst: resetn low after 2 beats of src2 -> valid=0, grant=0, data=0 immediately; after release src0 and src2 both valid -> src0 granted first.

Source files
------------

// File: rtl/avalon_st_arbiter.sv
// Four-source Avalon-ST round-robin arbiter with bounded bursts and a
// registered single-beat output stage.
module avalon_st_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [3:0]          src_valid,
  input  logic [4*DATA_W-1:0] src_data,
  output logic [3:0]          src_ready,
  output logic                valid,
  input  logic                ready,
  output logic [DATA_W-1:0]   data,
  output logic [3:0]          grant,
  output logic                busy
);

  localparam logic [3:0] MaxBurstC = 4'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [1:0]          last_q, last_d;
  logic [3:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [1:0]          gidx;
  logic [DATA_W-1:0]   src_beat;
  logic                open;
  logic                xfer;
  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [1:0]          cand;

  // Encode the one-hot owner and select its data lane.
  always_comb begin
    gidx     = 2'd0;
    src_beat = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        gidx     = 2'(i);
        src_beat = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign open      = !valid_q || ready;
  assign xfer      = (state_q == StBurst) && open && src_valid[gidx];
  assign src_ready = grant_q & {4{open}};

  // Round-robin search starting just after the previous owner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found && src_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state: arbitration, burst counting and release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBurst;
          grant_d = 4'b0001 << pick_idx;
          count_d = 4'd0;
        end
      end
      StBurst: begin
        if (xfer) begin
          count_d = count_q + 4'd1;
          if (count_q + 4'd1 == MaxBurstC) begin
            state_d = StIdle;
            grant_d = 4'b0000;
            last_d  = gidx;
          end
        end else if (open) begin
          // Owner went quiet while the sink could accept: give up the grant.
          state_d = StIdle;
          grant_d = 4'b0000;
          last_d  = gidx;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Output stage: loads only when open, otherwise holds the pending beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (open) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = src_beat;
      end
    end
  end

  // State registers; last starts at 3 so source 0 wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      last_q  <= 2'd3;
      count_q <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign grant = grant_q;
  assign busy  = (state_q == StBurst);

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Scoreboard bench for avalon_st_arbiter: random and directed stimulus,
// reference model of the arbitration rules, decoupled output monitor.
module tb_avalon_st_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [3:0]      src_valid = 4'b0000;
  logic [4*DW-1:0] src_data;
  logic [3:0]      src_ready;
  logic            valid;
  logic            ready = 1'b1;
  logic [DW-1:0]   data;
  logic [3:0]      grant;
  logic            busy;

  avalon_st_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .valid     (valid),
    .ready     (ready),
    .data      (data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source data: top two bits name the source, low bits a per-source sequence.
  int unsigned seq[4] = '{4, 0, 0, 0};
  always_comb begin
    for (int i = 0; i < 4; i++) src_data[i*DW +: DW] = DW'(i * 64 + int'(seq[i] % 64));
  end

  int        mode = 0;
  bit        force_stall = 1'b0;
  bit [3:0]  tx_mask = 4'b0000;

  // Driver: advance data on accepted beats, then present new valids/ready.
  always @(posedge clk) begin
    logic [3:0] nv;
    #1;
    for (int i = 0; i < 4; i++) if (tx_mask[i]) seq[i]++;
    nv = 4'b0000;
    case (mode)
      1: nv = {3'b000, seq[0] < 7};
      2: nv = 4'b1111;
      3: begin
        for (int i = 0; i < 4; i++) begin
          if (src_valid[i] && !tx_mask[i]) nv[i] = ($urandom_range(0, 99) < 80);
          else                             nv[i] = ($urandom_range(0, 99) < 50);
        end
      end
      4: nv = 4'b0100;
      5: nv = 4'b0101;
      6: nv = 4'b0001;
      default: nv = 4'b0000;
    endcase
    src_valid = nv;
    if (force_stall)    ready = 1'b0;
    else if (mode == 3) ready = ($urandom_range(0, 3) != 0);
    else                ready = 1'b1;
  end

  // Reference model: owner index (-1 none), beats taken, previous owner,
  // and whether a beat is sitting on the output.
  logic [DW-1:0] exp_q[$];
  int m_owner = -1;
  int m_last  = 3;
  int m_beats = 0;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    bit          open;
    bit          xfer;
    bit          found;
    bit          rel;
    int          c;
    logic [3:0]  g_exp;
    if (!resetn) begin
      m_owner = -1;
      m_last  = 3;
      m_beats = 0;
      m_valid = 1'b0;
      exp_q.delete();
      tx_mask = 4'b0000;
    end else begin
      open  = !m_valid || ready;
      g_exp = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk("valid", 32'(valid), 32'(m_valid));
      chk("grant", 32'(grant), 32'(g_exp));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("src_ready", 32'(src_ready), open ? 32'(g_exp) : 32'd0);
      xfer    = 1'b0;
      rel     = 1'b0;
      tx_mask = 4'b0000;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!found && src_valid[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_beats = 0;
          end
        end
      end else if (open) begin
        if (src_valid[m_owner]) begin
          xfer = 1'b1;
          tx_mask[m_owner] = 1'b1;
          exp_q.push_back(src_data[m_owner*DW +: DW]);
          m_beats++;
          rel = (m_beats == MB);
        end else begin
          rel = 1'b1;
        end
      end
      if (rel) begin
        m_last  = m_owner;
        m_owner = -1;
      end
      if (open) m_valid = xfer;
    end
  end

  // Monitor: every accepted output beat must be the oldest expected one;
  // a stalled beat must not change.
  logic [DW-1:0] acc[$];
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      hold_prev = 1'b0;
    end else begin
      if (valid && hold_prev) chk("stall_hold", 32'(data), 32'(prev_data));
      if (valid && ready) begin
        acc.push_back(data);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected none at %0t", data, $time);
        end else begin
          chk("beat", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = valid && !ready;
      prev_data = data;
    end
  end

  // Wait for a burst to start, then measure how many cycles busy stays high.
  task automatic measure_burst(output int len, output logic [3:0] g);
    int t;
    t = 0;
    len = 0;
    g = 4'b0000;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!busy) begin
      chk("burst_start_timeout", 32'(busy), 32'd1);
    end else begin
      g = grant;
      while (busy && len < 50) begin
        len++;
        @(negedge clk);
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    int         len;
    int         cnt;
    int         t;
    logic [3:0] g;
    logic [3:0] hg;
    logic [DW-1:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;

    // Single source, three beats 4,5,6
    mode = 1;
    repeat (15) @(negedge clk);
    chk("r032_count", 32'(acc.size()), 32'd3);
    for (int i = 0; i < 3; i++) if (i < acc.size()) chk("r032_data", 32'(acc[i]), 32'(4 + i));
    chk("r032_busy", 32'(busy), 32'd0);

    // Burst limit with a single continuous requester
    mode = 6;
    measure_burst(len, g);
    chk("r033_len", 32'(len), 32'(MB));
    chk("r033_grant", 32'(g), 32'd1);
    chk("r033_gap", 32'(grant), 32'd0);
    @(negedge clk);
    chk("r033_regrant", 32'(grant), 32'd1);
    measure_burst(len, g);
    chk("r033_len2", 32'(len), 32'(MB));
    mode = 0;
    repeat (8) @(negedge clk);

    // Round robin, all requesting, fresh priority
    reset_pulse();
    mode = 2;
    for (int b = 0; b < 5; b++) begin
      measure_burst(len, g);
      chk("r034_grant", 32'(g), 32'(1 << (b % 4)));
      chk("r034_len", 32'(len), 32'(MB));
    end

    // Back-pressure for three cycles mid-burst
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    force_stall = 1'b1;
    @(posedge clk);
    #2;
    held = data;
    hg   = grant;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r035_valid", 32'(valid), 32'd1);
      chk("r035_data", 32'(data), 32'(held));
      chk("r035_src_ready", 32'(src_ready), 32'd0);
      chk("r035_grant", 32'(grant), 32'(hg));
    end
    force_stall = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic and random sink stalls
    mode = 3;
    repeat (2000) @(negedge clk);

    // Reset in the middle of a source-2 burst
    mode = 0;
    repeat (10) @(negedge clk);
    mode = 4;
    cnt = 0;
    t = 0;
    while (cnt < 2 && t < 50) begin
      @(negedge clk);
      if (src_ready[2]) cnt++;
      t++;
    end
    chk("r036_two_beats", 32'(cnt), 32'd2);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("r036_valid", 32'(valid), 32'd0);
    chk("r036_grant", 32'(grant), 32'd0);
    chk("r036_data", 32'(data), 32'd0);
    chk("r036_src_ready", 32'(src_ready), 32'd0);
    mode = 5;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    t = 0;
    while (grant == 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("r036_first_grant", 32'(grant), 32'd1);
    mode = 0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
